// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl
//   Fades one PWM instance's duty cycle by driving its sel/d write port.
//   A start loads the period, writes the initial compare value and clears
//   the PWM counter. The compare value then moves toward cmp_end by step
//   once every `periods` PWM periods. Period ends are found by watching
//   the fed-back PWM counter wrap to zero.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start, abort    launch a fade (IDLE only) / stop any fade in progress
//   top_cfg         PWM period value
//   cmp_start       first compare value
//   cmp_end         last compare value
//   step            compare increment magnitude
//   periods         PWM periods per step (0 behaves as 1)
//   pwm_cnt         PWM counter fed back from the PWM block
//   pwm_sel, pwm_d  PWM write port: 0 run, 1 cmp, 2 top, 3 cnt
//   busy            high whenever not IDLE
//   done, err       one-cycle pulses: fade finished / start rejected
//   cur_cmp         compare value most recently written to the PWM
module pwm_fade_ctrl #(
  parameter int W  = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  top_cfg,
  input  logic [W-1:0]  cmp_start,
  input  logic [W-1:0]  cmp_end,
  input  logic [W-1:0]  step,
  input  logic [PW-1:0] periods,
  input  logic [W-1:0]  pwm_cnt,
  output logic [1:0]    pwm_sel,
  output logic [W-1:0]  pwm_d,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  cur_cmp
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_TOP, S_LOAD_CMP, S_CLR_CNT, S_RUN, S_STEP, S_DONE
  } state_t;

  state_t state;

  // Configuration captured at start; later changes on the inputs are ignored.
  logic [W-1:0]  top_q, start_q, end_q, step_q;
  logic [PW-1:0] per_q;
  logic          up_q;

  logic [W-1:0]  prev_cnt;
  logic [PW-1:0] wcnt;

  // Step upward without wrapping past the limit (sum kept in W+1 bits).
  function automatic logic [W-1:0] sat_up(input logic [W-1:0] cur,
                                          input logic [W-1:0] stp,
                                          input logic [W-1:0] lim);
    logic [W:0] sum;
    sum = {1'b0, cur} + {1'b0, stp};
    if (sum >= {1'b0, lim}) return lim;
    return sum[W-1:0];
  endfunction

  // Step downward without underflow: cur - stp < lim is tested as cur < lim + stp.
  function automatic logic [W-1:0] sat_dn(input logic [W-1:0] cur,
                                          input logic [W-1:0] stp,
                                          input logic [W-1:0] lim);
    if ({1'b0, cur} < ({1'b0, lim} + {1'b0, stp})) return lim;
    return cur - stp;
  endfunction

  logic          wrap;
  logic [PW-1:0] per_eff;
  logic [PW-1:0] wcnt_inc;
  logic [W-1:0]  next_cmp;

  assign wrap     = (pwm_cnt == '0) && (prev_cnt != '0);
  assign per_eff  = (per_q == '0) ? PW'(1) : per_q;
  assign wcnt_inc = wcnt + PW'(1);
  assign next_cmp = up_q ? sat_up(cur_cmp, step_q, end_q)
                         : sat_dn(cur_cmp, step_q, end_q);

  // Outputs are registered alongside the state they belong to, so pwm_sel
  // and pwm_d change on the same edge that enters the corresponding state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pwm_sel  <= 2'd0;
      pwm_d    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cur_cmp  <= '0;
      prev_cnt <= '0;
      wcnt     <= '0;
    end else begin
      pwm_sel  <= 2'd0;
      pwm_d    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      prev_cnt <= pwm_cnt;

      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              if ((top_cfg == '0) || (step == '0)) begin
                err <= 1'b1;
              end else begin
                top_q   <= top_cfg;
                start_q <= cmp_start;
                end_q   <= cmp_end;
                step_q  <= step;
                per_q   <= periods;
                up_q    <= (cmp_end >= cmp_start);
                state   <= S_LOAD_TOP;
                busy    <= 1'b1;
                pwm_sel <= 2'd2;
                pwm_d   <= top_cfg;
              end
            end
          end
          S_LOAD_TOP: begin
            state   <= S_LOAD_CMP;
            pwm_sel <= 2'd1;
            pwm_d   <= start_q;
            cur_cmp <= start_q;
          end
          S_LOAD_CMP: begin
            state   <= S_CLR_CNT;
            pwm_sel <= 2'd3;
            pwm_d   <= '0;
          end
          S_CLR_CNT: begin
            // The counter value seen this cycle predates the clear.
            state    <= S_RUN;
            prev_cnt <= '0;
            wcnt     <= '0;
          end
          S_RUN: begin
            if (wrap) begin
              if (wcnt_inc >= per_eff) begin
                if (cur_cmp == end_q) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  state   <= S_STEP;
                  wcnt    <= '0;
                  pwm_sel <= 2'd1;
                  pwm_d   <= next_cmp;
                  cur_cmp <= next_cmp;
                end
              end else begin
                wcnt <= wcnt_inc;
              end
            end
          end
          S_STEP: begin
            state <= S_RUN;
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // top_q is kept for visibility of the launched configuration only.
  logic unused_top;
  assign unused_top = ^top_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: a small PWM model closes the counter loop, and
// each fade is compared against a write list computed from the fade rules.
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] top_cfg = '0, cmp_start = '0, cmp_end = '0, step = '0;
  logic [7:0]  periods = '0;
  logic [15:0] pwm_cnt;
  logic [1:0]  pwm_sel;
  logic [15:0] pwm_d, cur_cmp;
  logic        busy, done, err;

  int n_chk  = 0;
  int n_fail = 0;

  pwm_fade_ctrl #(.W(16), .PW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .top_cfg(top_cfg), .cmp_start(cmp_start), .cmp_end(cmp_end),
    .step(step), .periods(periods), .pwm_cnt(pwm_cnt),
    .pwm_sel(pwm_sel), .pwm_d(pwm_d), .busy(busy), .done(done),
    .err(err), .cur_cmp(cur_cmp)
  );

  always #5 clk = ~clk;

  // PWM block model: counter runs only when sel==0; m_wraps counts the
  // running wraps since the last cmp or cnt write.
  logic [15:0] m_cnt, m_top, m_cmp;
  int          m_wraps;
  assign pwm_cnt = m_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_cnt <= '0; m_top <= '0; m_cmp <= '0; m_wraps <= 0;
    end else begin
      case (pwm_sel)
        2'd1: begin m_cmp <= pwm_d; m_wraps <= 0; end
        2'd2: m_top <= pwm_d;
        2'd3: begin m_cnt <= pwm_d; m_wraps <= 0; end
        default: begin
          if (m_cnt == m_top) begin
            m_cnt <= '0;
            if (m_top != '0) m_wraps <= m_wraps + 1;
          end else begin
            m_cnt <= m_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sel"}, 32'(pwm_sel), 0);
    chk({tag, "_d"}, 32'(pwm_d), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_cur"}, 32'(cur_cmp), 0);
  endtask

  // Launch one fade and follow it to completion. With hold set, start stays
  // high while busy; config inputs are scrambled after the launch either way.
  task automatic run_fade(input logic [15:0] t, input logic [15:0] cs,
                          input logic [15:0] ce, input logic [15:0] st,
                          input logic [7:0] per, input bit hold);
    int exp_q[$];
    int v, ics, ice, ist, pmax, idx;
    bit fin;
    ics = int'(cs); ice = int'(ce); ist = int'(st);
    pmax = (per == 8'd0) ? 1 : int'(per);
    v = ics;
    while (v != ice) begin
      if (ice >= ics) v = (v + ist > ice) ? ice : v + ist;
      else            v = (v - ist < ice) ? ice : v - ist;
      exp_q.push_back(v);
    end

    top_cfg = t; cmp_start = cs; cmp_end = ce; step = st; periods = per;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    top_cfg = 16'($urandom); cmp_start = 16'($urandom);
    cmp_end = 16'($urandom); step = 16'($urandom); periods = 8'($urandom);

    chk("ld_top_sel", 32'(pwm_sel), 2);
    chk("ld_top_d", 32'(pwm_d), 32'(t));
    chk("busy_rise", 32'(busy), 1);
    tick();
    chk("ld_cmp_sel", 32'(pwm_sel), 1);
    chk("ld_cmp_d", 32'(pwm_d), 32'(cs));
    chk("ld_cmp_cur", 32'(cur_cmp), 32'(cs));
    tick();
    chk("clr_sel", 32'(pwm_sel), 3);
    chk("clr_d", 32'(pwm_d), 0);

    idx = 0;
    fin = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      tick();
      if (pwm_sel == 2'd1) begin
        chk("step_d", 32'(pwm_d), (idx < exp_q.size()) ? 32'(exp_q[idx]) : 32'hDEAD_BEEF);
        chk("step_cur", 32'(cur_cmp), 32'(pwm_d));
        chk("step_gap", 32'(m_wraps), 32'(pmax));
        idx++;
      end else if (pwm_sel != 2'd0) begin
        chk("run_sel", 32'(pwm_sel), 0);
      end else begin
        chk("run_d", 32'(pwm_d), 0);
      end
      if (done) begin
        fin = 1'b1;
        start = 1'b0;
        chk("done_steps", 32'(idx), 32'(exp_q.size()));
        chk("done_gap", 32'(m_wraps), 32'(pmax));
        chk("done_cur", 32'(cur_cmp), 32'(ce));
        chk("done_busy", 32'(busy), 1);
      end
    end
    start = 1'b0;
    chk("fade_finished", 32'(fin), 1);
    tick();
    chk("end_busy", 32'(busy), 0);
    chk("end_done", 32'(done), 0);
  endtask

  initial begin
    logic [15:0] held;
    bit          found;
    int          rcs, rce, diff, rst_lo, rst_hi;

    rst = 1'b1;
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk_reset_outputs("idle");

    // Directed fades
    run_fade(16'd9, 16'd2, 16'd8, 16'd3, 8'd1, 1'b0);
    run_fade(16'd5, 16'd8, 16'd1, 16'd4, 8'd2, 1'b0);
    run_fade(16'd3, 16'hFFF0, 16'hFFFF, 16'h0020, 8'd1, 1'b0);
    run_fade(16'd4, 16'd10, 16'd30, 16'd10, 8'd0, 1'b0);
    run_fade(16'd4, 16'd10, 16'd30, 16'd10, 8'd3, 1'b1);
    run_fade(16'd3, 16'd7, 16'd7, 16'd5, 8'd2, 1'b0);
    run_fade(16'd2, 16'd5, 16'd0, 16'd9, 8'd1, 1'b0);

    // Rejected starts
    top_cfg = 16'd0; step = 16'd5; start = 1'b1;
    tick(); start = 1'b0;
    chk("err_top", 32'(err), 1);
    chk("err_top_busy", 32'(busy), 0);
    chk("err_top_sel", 32'(pwm_sel), 0);
    tick();
    chk("err_top_pulse", 32'(err), 0);
    chk("err_top_idle", 32'(busy), 0);

    top_cfg = 16'd9; step = 16'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("err_step", 32'(err), 1);
    chk("err_step_busy", 32'(busy), 0);
    tick();
    chk("err_step_pulse", 32'(err), 0);

    // start and abort together
    top_cfg = 16'd9; cmp_start = 16'd1; cmp_end = 16'd5; step = 16'd1;
    periods = 8'd1; start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    chk("coll_busy", 32'(busy), 0);
    chk("coll_sel", 32'(pwm_sel), 0);
    chk("coll_err", 32'(err), 0);
    tick();
    chk("coll_busy2", 32'(busy), 0);

    // abort in RUN after the first step write
    top_cfg = 16'd4; cmp_start = 16'd0; cmp_end = 16'd100; step = 16'd10;
    periods = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    found = 1'b0;
    held = '0;
    for (int c = 0; c < 500 && !found; c++) begin
      tick();
      if (pwm_sel == 2'd1) begin
        found = 1'b1;
        held = pwm_d;
      end
    end
    chk("abort_found_step", 32'(found), 1);
    chk("abort_step_val", 32'(held), 10);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sel", 32'(pwm_sel), 0);
    chk("abort_cur", 32'(cur_cmp), 32'(held));
    chk("abort_done", 32'(done), 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("abort_quiet", {28'd0, done, busy, pwm_sel}, 0);
    end

    // reset while in LOAD_CMP
    top_cfg = 16'd7; cmp_start = 16'd3; cmp_end = 16'd6; step = 16'd1;
    periods = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("rst_in_ldcmp_sel", 32'(pwm_sel), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("rst_mid");

    // Randomized fades
    for (int r = 0; r < 20; r++) begin
      rcs = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) rce = ($urandom_range(0, 1) == 1) ? 65535 : 0;
      else rce = int'($urandom_range(0, 65535));
      diff = (rce > rcs) ? rce - rcs : rcs - rce;
      rst_lo = diff / 6 + 1;
      rst_hi = diff + diff / 2 + 1;
      if (rst_hi > 65535) rst_hi = 65535;
      if (rst_lo > rst_hi) rst_lo = rst_hi;
      run_fade(16'($urandom_range(1, 7)), 16'(rcs), 16'(rce),
               16'($urandom_range(rst_lo, rst_hi)),
               8'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Sequencer that drives the PWM block's `sel`/`d` write port to fade its duty cycle.
- On `start` it:
  - loads the period (`top`),
  - loads the initial compare value,
  - clears the PWM counter,
  - steps `cmp` from `cmp_start` toward `cmp_end` by `step` once every `periods` PWM periods.
- Period boundaries come from watching the PWM counter wrap.
- Sits between the register/CPU side and one PWM instance, and owns that instance's write port exclusively.

Parameters:
W, 16, data width of PWM counter/compare/top (matches PWM `d`).
PW, 8, width of `periods` (PWM periods per fade step).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin fade; sampled only in IDLE
abort  in  1  stop fade; wins over everything except rst
top_cfg  in  W  PWM period value
cmp_start  in  W  initial compare value
cmp_end  in  W  final compare value
step  in  W  compare increment magnitude
periods  in  PW  PWM periods between steps (0 treated as 1)
pwm_cnt  in  W  PWM counter value, fed back from the PWM block
pwm_sel  out  2  PWM write select: 0 run, 1 write cmp, 2 write top, 3 write cnt
pwm_d  out  W  PWM write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when fade completes
err  out  1  one-cycle pulse when start is rejected
cur_cmp  out  W  compare value last written to the PWM

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; pwm_sel=0, pwm_d=0, busy=0, done=0, err=0, cur_cmp=0.
  - Internal wrap counter and prev_cnt cleared.
- Outputs are registered; pwm_sel/pwm_d reflect the current state.
- Every state other than LOAD_TOP, LOAD_CMP, CLR_CNT, STEP drives pwm_sel=0, pwm_d=0.
- States and transitions:
  - IDLE:
    - start with top_cfg==0 or step==0 -> err pulse next cycle, stay IDLE.
    - start otherwise -> latch all config inputs, go LOAD_TOP.
    - Config inputs are ignored after latching.
  - LOAD_TOP (1 cycle): pwm_sel=2, pwm_d=top latched -> LOAD_CMP.
  - LOAD_CMP (1 cycle): pwm_sel=1, pwm_d=cmp_start; cur_cmp<=cmp_start -> CLR_CNT.
  - CLR_CNT (1 cycle): pwm_sel=3, pwm_d=0; prev_cnt<=0, wrap count<=0 -> RUN.
  - RUN:
    - pwm_sel=0.
    - wrap = (pwm_cnt==0) && (prev_cnt!=0); prev_cnt<=pwm_cnt every cycle.
    - On wrap, wrap count increments.
    - When wrap count reaches max(periods,1):
      - cur_cmp==cmp_end -> DONE.
      - otherwise -> STEP, wrap count<=0.
  - STEP (1 cycle): pwm_sel=1, pwm_d=next; cur_cmp<=next -> RUN.
  - DONE (1 cycle): done=1 -> IDLE.
- Direction is latched at start:
  - up if cmp_end>=cmp_start, else down.
- next:
  - up: min(cur+step, cmp_end), computed in W+1 bits so there is no wrap-around.
  - down: max(cur-step, cmp_end), with no underflow.
- cmp_start==cmp_end: after the initial loads, wait one step interval, then DONE; no STEP write issued.
- abort:
  - In any non-IDLE state -> IDLE next cycle; pwm_sel=0, no done.
  - The PWM keeps whatever was last written; cur_cmp holds.
- start while busy is ignored.
- abort and start in the same IDLE cycle: abort wins, nothing launched.
- rst mid-fade returns to IDLE; PWM registers are not touched by this block.
- Latency:
  - start to first PWM write (sel=2) = 1 cycle.
  - Three write cycles precede RUN.

Test Plan:
- top=9, cmp_start=2, cmp_end=8, step=3, periods=1, with a PWM model attached:
  - writes seen are sel2/9, sel1/2, sel3/0;
  - after each 10-cycle period, sel1 writes 5 then 8;
  - done pulses one period after the 8 write; busy falls with done.
- Down fade: cmp_start=8, cmp_end=1, step=4:
  - compare writes 8, 4, 1 (clamped); no underflow.
- Up overflow: W=16, cmp_start=0xFFF0, cmp_end=0xFFFF, step=0x20:
  - second write is 0xFFFF, not a wrapped value.
- periods=0 vs periods=3: step writes are spaced 1 and 3 PWM periods apart, respectively.
- Error and collision handling:
  - start with top_cfg=0 -> err one cycle, busy stays 0.
  - start with step=0 -> err.
  - start+abort in the same cycle -> nothing launched.
- abort asserted in RUN after the first step:
  - next cycle IDLE, pwm_sel=0, cur_cmp holds its last value, no done.
  - rst asserted during LOAD_CMP -> all outputs at their reset values the following cycle.
